// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding and request entry layout for mem_access_unit
package mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Entry layout, MSB first: {write, tag, addr[31:0], data[31:0]}
  function automatic int entry_width(input int tag_width);
    return 1 + tag_width + 32 + 32;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core token, cache request/response and result handshakes
interface mem_access_unit_if #(
  parameter int TAG_WIDTH = 8
);
  logic                 IN_VALID;
  logic                 IN_WRITE;
  logic [31:0]          IN_ADDR;
  logic [31:0]          IN_DATA;
  logic [TAG_WIDTH-1:0] IN_TAG;
  logic                 IN_READY;
  logic                 REQ_ADDR_VALID;
  logic [31:0]          REQ_ADDR;
  logic                 REQ_DATA_VALID;
  logic [31:0]          REQ_DATA;
  logic                 REQ_READY;
  logic                 RSP_VALID;
  logic [31:0]          RSP_DATA;
  logic                 RSP_READY;
  logic                 OUT_VALID;
  logic [31:0]          OUT_DATA;
  logic [TAG_WIDTH-1:0] OUT_TAG;
  logic                 OUT_READY;

  modport master (
    input  IN_VALID, IN_WRITE, IN_ADDR, IN_DATA, IN_TAG, REQ_READY, RSP_VALID, RSP_DATA, OUT_READY,
    output IN_READY, REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RSP_READY,
           OUT_VALID, OUT_DATA, OUT_TAG
  );

  modport slave (
    output IN_VALID, IN_WRITE, IN_ADDR, IN_DATA, IN_TAG, REQ_READY, RSP_VALID, RSP_DATA, OUT_READY,
    input  IN_READY, REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RSP_READY,
           OUT_VALID, OUT_DATA, OUT_TAG
  );
endinterface

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO, head entry visible combinationally
module mem_req_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - buffers tagged load/store tokens and issues them one at a time to the cache
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TAG_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int STORE_ACK = 1
) (
  input  logic               CLK,
  input  logic               RST,
  mem_access_unit_if.master  bus
);

  localparam int EW = entry_width(TAG_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam bit ACK_STORES = (STORE_ACK != 0);

  logic [EW-1:0]        head;
  logic [CW-1:0]        count;
  logic                 fifo_full, fifo_empty, in_ready, push;
  logic                 head_write;
  logic [TAG_WIDTH-1:0] head_tag;
  logic [31:0]          head_addr, head_data;

  state_t state_q, state_d;
  logic   rsp_ready, out_valid, issue_fire, capture, load_req;

  logic                 req_addr_valid_q, req_data_valid_q;
  logic [31:0]          req_addr_q, req_data_q;
  logic                 pend_write_q;
  logic [TAG_WIDTH-1:0] pend_tag_q;
  logic [31:0]          pend_data_q;
  logic [31:0]          out_data_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full && !RST;
  assign push       = bus.IN_VALID && in_ready;

  assign head_write = head[EW-1];
  assign head_tag   = head[64 +: TAG_WIDTH];
  assign head_addr  = head[63:32];
  assign head_data  = head[31:0];

  mem_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data ({bus.IN_WRITE, bus.IN_TAG, bus.IN_ADDR, bus.IN_DATA}),
    .pop       (issue_fire),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: if (bus.REQ_READY) state_d = ST_WAIT;
      ST_WAIT:  if (bus.RSP_VALID) state_d = (pend_write_q && !ACK_STORES) ? ST_IDLE : ST_RESP;
      ST_RESP:  if (bus.OUT_READY) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RESP hands straight to ISSUE when more work is queued, skipping the IDLE cycle.
  always_comb begin
    rsp_ready  = (state_q == ST_WAIT);
    out_valid  = (state_q == ST_RESP);
    issue_fire = (state_q == ST_ISSUE) && bus.REQ_READY;
    capture    = (state_q == ST_WAIT) && bus.RSP_VALID;
    load_req   = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.OUT_READY));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_addr_valid_q <= 1'b0;
      req_data_valid_q <= 1'b0;
      req_addr_q       <= '0;
      req_data_q       <= '0;
      pend_write_q     <= 1'b0;
      pend_tag_q       <= '0;
      pend_data_q      <= '0;
      out_data_q       <= '0;
      out_tag_q        <= '0;
    end else begin
      if (load_req) begin
        req_addr_valid_q <= 1'b1;
        req_data_valid_q <= head_write;
        req_addr_q       <= head_addr;
        req_data_q       <= head_data;
      end
      if (issue_fire) begin
        req_addr_valid_q <= 1'b0;
        req_data_valid_q <= 1'b0;
        pend_write_q     <= head_write;
        pend_tag_q       <= head_tag;
        pend_data_q      <= head_data;
      end
      // A store acknowledgement returns the value that was written.
      if (capture) begin
        out_data_q <= pend_write_q ? pend_data_q : bus.RSP_DATA;
        out_tag_q  <= pend_tag_q;
      end
    end
  end

  assign bus.IN_READY       = in_ready;
  assign bus.REQ_ADDR_VALID = req_addr_valid_q;
  assign bus.REQ_DATA_VALID = req_data_valid_q;
  assign bus.REQ_ADDR       = req_addr_q;
  assign bus.REQ_DATA       = req_data_q;
  assign bus.RSP_READY      = rsp_ready;
  assign bus.OUT_VALID      = out_valid;
  assign bus.OUT_DATA       = out_data_q;
  assign bus.OUT_TAG        = out_tag_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - bench for mem_access_unit with STORE_ACK=1 and STORE_ACK=0 instances
module tb_mem_access_unit;

  localparam int TW = 8;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_access_unit_if #(.TAG_WIDTH(TW)) bus0 ();
  mem_access_unit_if #(.TAG_WIDTH(TW)) bus1 ();

  mem_access_unit #(.TAG_WIDTH(TW), .DEPTH(DEPTH), .STORE_ACK(1)) u0 (.CLK(CLK), .RST(RST), .bus(bus0));
  mem_access_unit #(.TAG_WIDTH(TW), .DEPTH(DEPTH), .STORE_ACK(0)) u1 (.CLK(CLK), .RST(RST), .bus(bus1));

  logic          d_in_valid [2];
  logic          d_in_write [2];
  logic [31:0]   d_in_addr  [2];
  logic [31:0]   d_in_data  [2];
  logic [TW-1:0] d_in_tag   [2];
  logic          d_req_ready[2];
  logic          d_rsp_valid[2];
  logic [31:0]   d_rsp_data [2];
  logic          d_out_ready[2];

  assign bus0.IN_VALID = d_in_valid[0];   assign bus1.IN_VALID = d_in_valid[1];
  assign bus0.IN_WRITE = d_in_write[0];   assign bus1.IN_WRITE = d_in_write[1];
  assign bus0.IN_ADDR  = d_in_addr[0];    assign bus1.IN_ADDR  = d_in_addr[1];
  assign bus0.IN_DATA  = d_in_data[0];    assign bus1.IN_DATA  = d_in_data[1];
  assign bus0.IN_TAG   = d_in_tag[0];     assign bus1.IN_TAG   = d_in_tag[1];
  assign bus0.REQ_READY = d_req_ready[0]; assign bus1.REQ_READY = d_req_ready[1];
  assign bus0.RSP_VALID = d_rsp_valid[0]; assign bus1.RSP_VALID = d_rsp_valid[1];
  assign bus0.RSP_DATA  = d_rsp_data[0];  assign bus1.RSP_DATA  = d_rsp_data[1];
  assign bus0.OUT_READY = d_out_ready[0]; assign bus1.OUT_READY = d_out_ready[1];

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [TW-1:0] t; } tok_t;
  typedef struct { logic [31:0] d; logic [TW-1:0] t; } exp_t;
  typedef struct {
    logic in_ready; logic req_av; logic req_dv; logic [31:0] req_a; logic [31:0] req_d;
    logic rsp_ready; logic out_valid; logic [31:0] out_data; logic [TW-1:0] out_tag;
  } obs_t;
  typedef struct {
    int inst; logic w; logic [31:0] a; logic [31:0] d; logic [TW-1:0] t;
    bit has_out; logic [31:0] ed; logic [TW-1:0] et;
  } vec_t;

  tok_t drv_q[2][$];
  exp_t exp_q[2][$];
  logic [31:0] ref_mem[logic [32:0]];
  logic [31:0] cmem[logic [32:0]];

  bit push_prev[2], req_hs_prev[2], rsp_hs_prev[2], c_pend[2], c_rsp_v[2], stall_prev[2];
  int c_lat[2];
  tok_t c_req[2];
  logic [31:0] c_rdata[2];
  logic [31:0] last_d[2];
  logic [TW-1:0] last_t[2];

  int req_mode[2];   // 0 hold low, 1 always ready, 2 random
  int out_mode[2];
  bit hold_rsp, spur_en;
  int checks = 0;
  int errors = 0;

  function automatic obs_t sample(input int i);
    obs_t o;
    if (i == 0)
      o = '{bus0.IN_READY, bus0.REQ_ADDR_VALID, bus0.REQ_DATA_VALID, bus0.REQ_ADDR, bus0.REQ_DATA,
            bus0.RSP_READY, bus0.OUT_VALID, bus0.OUT_DATA, bus0.OUT_TAG};
    else
      o = '{bus1.IN_READY, bus1.REQ_ADDR_VALID, bus1.REQ_DATA_VALID, bus1.REQ_ADDR, bus1.REQ_DATA,
            bus1.RSP_READY, bus1.OUT_VALID, bus1.OUT_DATA, bus1.OUT_TAG};
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enqueue a token and derive its expected result from a plain memory model.
  task automatic send(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [TW-1:0] t, input bit model);
    logic [32:0] key;
    key = {i[0], a};
    drv_q[i].push_back('{w, a, d, t});
    if (w) ref_mem[key] = d;
    if (model && (!w || i == 0))
      exp_q[i].push_back('{w ? d : (ref_mem.exists(key) ? ref_mem[key] : 32'h0), t});
  endtask

  // Core, cache and result-sink models for instance i, run once per cycle on the falling edge.
  task automatic env(input int i);
    obs_t o;
    logic [32:0] key;
    o = sample(i);
    if (RST) begin
      drv_q[i].delete(); exp_q[i].delete();
      push_prev[i] = 0; req_hs_prev[i] = 0; rsp_hs_prev[i] = 0;
      c_pend[i] = 0; c_rsp_v[i] = 0; stall_prev[i] = 0;
      d_in_valid[i] = 0; d_req_ready[i] = 0; d_rsp_valid[i] = 0; d_out_ready[i] = 0;
      return;
    end
    if (push_prev[i]) void'(drv_q[i].pop_front());
    if (rsp_hs_prev[i]) c_rsp_v[i] = 0;
    if (req_hs_prev[i]) begin
      key = {i[0], c_req[i].a};
      if (c_req[i].w) cmem[key] = c_req[i].d;
      c_rdata[i] = c_req[i].w ? c_req[i].d : (cmem.exists(key) ? cmem[key] : 32'h0);
      c_pend[i] = 1;
      c_lat[i] = $urandom_range(0, 3);
    end
    if (c_pend[i] && !hold_rsp) begin
      if (c_lat[i] == 0) begin c_rsp_v[i] = 1; c_pend[i] = 0; end
      else c_lat[i]--;
    end
    d_rsp_valid[i] = c_rsp_v[i];
    d_rsp_data[i]  = c_rdata[i];
    if (spur_en && !c_rsp_v[i] && !o.rsp_ready && $urandom_range(0, 3) == 0) begin
      d_rsp_valid[i] = 1;
      d_rsp_data[i]  = $urandom;
    end
    d_req_ready[i] = (req_mode[i] == 1) || (req_mode[i] == 2 && $urandom_range(0, 1) == 1);
    req_hs_prev[i] = o.req_av && d_req_ready[i];
    c_req[i] = '{o.req_dv, o.req_a, o.req_d, '0};
    rsp_hs_prev[i] = c_rsp_v[i] && o.rsp_ready;

    d_in_valid[i] = (drv_q[i].size() > 0);
    if (d_in_valid[i]) begin
      d_in_write[i] = drv_q[i][0].w; d_in_addr[i] = drv_q[i][0].a;
      d_in_data[i]  = drv_q[i][0].d; d_in_tag[i]  = drv_q[i][0].t;
    end
    push_prev[i] = d_in_valid[i] && o.in_ready;

    d_out_ready[i] = (out_mode[i] == 1) || (out_mode[i] == 2 && $urandom_range(0, 1) == 1);
    if (stall_prev[i])
      check("out_hold", {o.out_valid, o.out_data, o.out_tag}, {1'b1, last_d[i], last_t[i]});
    if (o.out_valid && d_out_ready[i]) begin
      if (exp_q[i].size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out inst%0d: got data %h tag %h expected none", i, o.out_data, o.out_tag);
      end else begin
        exp_t e;
        e = exp_q[i].pop_front();
        check($sformatf("out_token inst%0d", i), {o.out_data, o.out_tag}, {e.d, e.t});
      end
    end
    stall_prev[i] = o.out_valid && !d_out_ready[i];
    last_d[i] = o.out_data;
    last_t[i] = o.out_tag;
  endtask

  task automatic step();
    @(negedge CLK);
    env(0);
    env(1);
  endtask

  task automatic wait_drain(input int i, input int budget);
    int n;
    n = 0;
    while ((exp_q[i].size() != 0 || drv_q[i].size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout inst%0d: %0d results still pending, required 0", i, exp_q[i].size());
    end
    repeat (10) step();
  endtask

  function automatic logic [127:0] all_outs(input obs_t o);
    return {19'd0, o.in_ready, o.req_av, o.req_dv, o.req_a, o.req_d, o.rsp_ready, o.out_valid,
            o.out_data, o.out_tag};
  endfunction

  vec_t vt[4];

  initial begin
    vt[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 8'h11, 1, 32'hDEADBEEF, 8'h11};
    vt[1] = '{0, 1'b0, 32'h100, 32'h0,        8'h12, 1, 32'hDEADBEEF, 8'h12};
    vt[2] = '{1, 1'b1, 32'h200, 32'h12345678, 8'h01, 0, 32'h0,        8'h00};
    vt[3] = '{1, 1'b0, 32'h200, 32'h0,        8'h02, 1, 32'h12345678, 8'h02};

    for (int i = 0; i < 2; i++) begin
      d_in_valid[i] = 0; d_in_write[i] = 0; d_in_addr[i] = 0; d_in_data[i] = 0; d_in_tag[i] = 0;
      d_req_ready[i] = 0; d_rsp_valid[i] = 0; d_rsp_data[i] = 0; d_out_ready[i] = 0;
      c_rdata[i] = 0; req_mode[i] = 1; out_mode[i] = 1;
    end
    hold_rsp = 0;
    spur_en = 0;

    RST = 1;
    repeat (3) step();
    check("reset_outs_u0", all_outs(sample(0)), '0);
    check("reset_outs_u1", all_outs(sample(1)), '0);
    RST = 0;
    step();
    check("in_ready_after_reset_u0", {127'd0, sample(0).in_ready}, 128'd1);
    check("in_ready_after_reset_u1", {127'd0, sample(1).in_ready}, 128'd1);

    // Directed store/load vectors on both instances
    req_mode[0] = 2; req_mode[1] = 2;
    for (int k = 0; k < 4; k++) begin
      send(vt[k].inst, vt[k].w, vt[k].a, vt[k].d, vt[k].t, 0);
      if (vt[k].has_out) exp_q[vt[k].inst].push_back('{vt[k].ed, vt[k].et});
    end
    wait_drain(0, 200);
    wait_drain(1, 200);

    // DEPTH+2 tokens with the result sink stalled: the FIFO fills and the last token is held
    out_mode[0] = 0; req_mode[0] = 1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k % 2 == 0) send(0, 1'b1, 32'h300 + 32'(4 * k), 32'h1111 * 32'(k + 1), 8'(8'h20 + k), 1);
      else            send(0, 1'b0, 32'h300 + 32'(4 * (k - 1)), 32'h0, 8'(8'h20 + k), 1);
    end
    repeat (20) step();
    check("fill_in_ready", {127'd0, sample(0).in_ready}, 128'd0);
    check("fill_token_held", 128'(drv_q[0].size()), 128'd1);
    out_mode[0] = 1;
    wait_drain(0, 300);

    // Push into a FIFO at DEPTH-1 in the same cycle the head is popped
    out_mode[0] = 0; req_mode[0] = 0;
    for (int k = 0; k < DEPTH - 1; k++) send(0, 1'b0, 32'h100, 32'h0, 8'(8'h40 + k), 1);
    for (int n = 0; n < 30 && drv_q[0].size() != 0; n++) step();
    check("pre_pop_req_valid", {126'd0, sample(0).req_av, sample(0).in_ready}, 128'd3);
    send(0, 1'b0, 32'h300, 32'h0, 8'h43, 1);
    req_mode[0] = 1;
    step();
    step();
    check("push_pop_in_ready", {127'd0, sample(0).in_ready}, 128'd1);
    check("push_pop_accepted", 128'(drv_q[0].size()), 128'd0);
    send(0, 1'b0, 32'h308, 32'h0, 8'h44, 1);
    repeat (10) step();
    check("push_pop_then_full", {127'd0, sample(0).in_ready}, 128'd0);
    out_mode[0] = 1;
    wait_drain(0, 300);

    // Random store/load pairs with random back-pressure and stray responses
    out_mode[0] = 2; out_mode[1] = 2; req_mode[0] = 2; req_mode[1] = 2; spur_en = 1;
    for (int p = 0; p < 100; p++) begin
      logic [31:0] a, d;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      d = $urandom;
      send(0, 1'b1, a, d, 8'(2 * p), 1);
      send(0, 1'b0, a, 32'h0, 8'(2 * p + 1), 1);
      if (p < 30) begin
        send(1, 1'b1, a, d ^ 32'h5A5A5A5A, 8'(2 * p), 1);
        send(1, 1'b0, a, 32'h0, 8'(2 * p + 1), 1);
      end
    end
    wait_drain(0, 20000);
    wait_drain(1, 5000);

    // Reset while a load is waiting for its response
    spur_en = 0; out_mode[0] = 1; req_mode[0] = 1; hold_rsp = 1;
    send(0, 1'b0, 32'h100, 32'h0, 8'h77, 1);
    begin
      int n;
      n = 0;
      while (!sample(0).rsp_ready && n < 30) begin step(); n++; end
      check("reach_wait", {127'd0, sample(0).rsp_ready}, 128'd1);
    end
    RST = 1;
    step();
    check("mid_op_reset_outs", all_outs(sample(0)), '0);
    RST = 0;
    hold_rsp = 0;
    step();
    check("mid_op_reset_in_ready", {127'd0, sample(0).in_ready}, 128'd1);
    send(0, 1'b0, 32'h100, 32'h0, 8'h78, 1);
    wait_drain(0, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
